// File: rtl/seg_scan_bcd.sv
// Seven-segment scanner for the three DDS control words.
// A shared double-dabble engine converts each field in turn, the finished
// frame is committed to the display buffer in one cycle, and the buffer is
// time-multiplexed over ND digit positions with a blank slot between digits.
module seg_scan_bcd #(
   parameter int W1             = 6,
   parameter int W2             = 8,
   parameter int W3             = 9,
   parameter int D1             = 2,
   parameter int D2             = 3,
   parameter int D3             = 3,
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit CAT_ACTIVE_LOW = 1'b1
) (
   input  logic                  seg_clock,
   input  logic                  sys_rst,
   input  logic [W1-1:0]         Fword1,
   input  logic [W2-1:0]         Fword2,
   input  logic [W3-1:0]         Pword2,
   input  logic [D1+D2+D3-1:0]   dp_mask,
   input  logic                  blank_en,
   output logic [7:0]            seg_output,
   output logic [D1+D2+D3-1:0]   cat_output,
   output logic                  frame_done
);

   localparam int ND  = D1 + D2 + D3;
   localparam int WM  = (W1 > W2) ? ((W1 > W3) ? W1 : W3) : ((W2 > W3) ? W2 : W3);
   // at least four nibbles so every possible digit slot has a BCD source
   localparam int NN  = (WM / 3 + 1 > 4) ? WM / 3 + 1 : 4;
   localparam int NB  = 4 * NN;
   localparam int CW  = $clog2(WM + 1);
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int IW  = (ND > 1) ? $clog2(ND) : 1;

   localparam logic [3:0]    C_DASH  = 4'hA;
   localparam logic [3:0]    C_BLANK = 4'hF;
   localparam logic [7:0]    SEG_XOR = {8{SEG_ACTIVE_LOW}};
   localparam logic [ND-1:0] CAT_XOR = {ND{CAT_ACTIVE_LOW}};

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

   state_t               state;
   logic [1:0]           ptr;
   logic [CW-1:0]        cnt;
   logic [WM-1:0]        bin;
   logic [NB-1:0]        bcd, bcd_adj;
   logic [W1-1:0]        snap_a;
   logic [W2-1:0]        snap_b;
   logic [W3-1:0]        snap_c;
   logic                 snap_blank;
   logic [ND-1:0][3:0]   work, disp, store_buf;
   logic [3:0][3:0]      fdig;
   logic                 ovf, above;
   logic [WM-1:0]        fval;
   int                   fo, fd, fw;
   logic [DW-1:0]        div;
   logic [IW-1:0]        idx;

   function automatic logic [6:0] seg_code(input logic [3:0] c);
      case (c)
         4'd0:    seg_code = 7'h3F;
         4'd1:    seg_code = 7'h06;
         4'd2:    seg_code = 7'h5B;
         4'd3:    seg_code = 7'h4F;
         4'd4:    seg_code = 7'h66;
         4'd5:    seg_code = 7'h6D;
         4'd6:    seg_code = 7'h7D;
         4'd7:    seg_code = 7'h07;
         4'd8:    seg_code = 7'h7F;
         4'd9:    seg_code = 7'h6F;
         C_DASH:  seg_code = 7'h40;
         default: seg_code = 7'h00;
      endcase
   endfunction

   // Select offset, digit count, width and left-aligned value of the current field
   always_comb begin
      fo   = 0;
      fd   = D3;
      fw   = W3;
      fval = WM'(snap_c) << (WM - W3);
      case (ptr)
         2'd0: begin
            fo = D3 + D2; fd = D1; fw = W1;
            fval = WM'(snap_a) << (WM - W1);
         end
         2'd1: begin
            fo = D3; fd = D2; fw = W2;
            fval = WM'(snap_b) << (WM - W2);
         end
         default: ;
      endcase
   end

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < NN; n++)
         if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
   end

   // Turn the finished BCD into digit codes with overflow and blanking applied
   always_comb begin
      ovf   = 1'b0;
      above = 1'b0;
      fdig  = '0;
      for (int n = 0; n < NN; n++)
         if (n >= fd && bcd[4*n +: 4] != 4'd0) ovf = 1'b1;
      for (int j = 3; j >= 0; j--) begin
         if (j < fd && bcd[4*j +: 4] != 4'd0) above = 1'b1;
         if (ovf)                               fdig[j] = C_DASH;
         else if (above || j == 0 || !snap_blank) fdig[j] = bcd[4*j +: 4];
         else                                   fdig[j] = C_BLANK;
      end
      store_buf = work;
      for (int p = 0; p < ND; p++)
         if (p >= fo && p < fo + fd) store_buf[p] = fdig[2'(p - fo)];
   end

   // Converter FSM: snapshot, then load/shift/store each field, commit on the last
   always_ff @(posedge seg_clock or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         bin        <= '0;
         bcd        <= '0;
         snap_a     <= '0;
         snap_b     <= '0;
         snap_c     <= '0;
         snap_blank <= 1'b0;
         work       <= {ND{C_BLANK}};
         disp       <= {ND{C_BLANK}};
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               snap_a     <= Fword1;
               snap_b     <= Fword2;
               snap_c     <= Pword2;
               snap_blank <= blank_en;
               ptr        <= '0;
               state      <= LOAD;
            end
            LOAD: begin
               bin   <= fval;
               bcd   <= '0;
               cnt   <= CW'(fw);
               state <= SHIFT;
            end
            SHIFT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= STORE;
            end
            STORE: begin
               work <= store_buf;
               if (ptr == 2'd2) begin
                  disp       <= store_buf;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  ptr   <= ptr + 1'b1;
                  state <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scan divider and digit index
   always_ff @(posedge seg_clock or posedge sys_rst) begin
      if (sys_rst) begin
         div <= '0;
         idx <= '0;
      end else if (div == DW'(SCAN_DIV - 1)) begin
         div <= '0;
         idx <= (idx == IW'(ND - 1)) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Registered drive: first cycle of each slot is dark to stop ghosting
   always_ff @(posedge seg_clock or posedge sys_rst) begin
      if (sys_rst) begin
         seg_output <= SEG_XOR;
         cat_output <= CAT_XOR;
      end else if (div == '0) begin
         seg_output <= SEG_XOR;
         cat_output <= CAT_XOR;
      end else begin
         seg_output <= {dp_mask[idx], seg_code(disp[idx])} ^ SEG_XOR;
         cat_output <= (ND'(1) << idx) ^ CAT_XOR;
      end
   end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed bench for seg_scan_bcd: reset, frame timing, digit patterns,
// overflow on a narrower instance, scan order and mid-frame reset.
module tb_seg_scan_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] f1 = '0;
   logic [7:0] f2 = '0;
   logic [8:0] pw = '0;
   logic [7:0] dp = '0;
   logic [6:0] dp7 = '0;
   logic       blank = 1'b1;
   logic [7:0] seg, seg_ov;
   logic [7:0] cat;
   logic [6:0] cat_ov;
   logic       fdone, fdone_ov;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg_scan_bcd #(.SCAN_DIV(4)) dut (
      .seg_clock(clk), .sys_rst(rst), .Fword1(f1), .Fword2(f2), .Pword2(pw),
      .dp_mask(dp), .blank_en(blank), .seg_output(seg), .cat_output(cat),
      .frame_done(fdone));

   seg_scan_bcd #(.SCAN_DIV(4), .D2(2)) dut_ov (
      .seg_clock(clk), .sys_rst(rst), .Fword1(f1), .Fword2(f2), .Pword2(pw),
      .dp_mask(dp7), .blank_en(blank), .seg_output(seg_ov), .cat_output(cat_ov),
      .frame_done(fdone_ov));

   task automatic get_digit(input int i, output logic [7:0] s, output bit ok);
      ok = 1'b0;
      s  = 'x;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (cat === ~(8'd1 << i)) begin s = seg; ok = 1'b1; end
      end
   endtask

   task automatic get_digit_ov(input int i, output logic [7:0] s, output bit ok);
      ok = 1'b0;
      s  = 'x;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (cat_ov === ~(7'd1 << i)) begin s = seg_ov; ok = 1'b1; end
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int c = 0; c < n; c++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      f1 = 6'd1; f2 = 8'd2; pw = 9'd128; blank = 1'b1; dp = '0;
      wait_cycles(3);
      vectors++;
      if (seg !== 8'h00) begin miscompares++; $display("FAIL reset_seg got %h expected 00", seg); end
      vectors++;
      if (cat !== 8'hFF) begin miscompares++; $display("FAIL reset_cat got %h expected ff", cat); end
      vectors++;
      if (fdone !== 1'b0) begin miscompares++; $display("FAIL reset_fdone got %b expected 0", fdone); end
      rst = 1'b0;
      for (int e = 1; e <= 61; e++) begin
         @(posedge clk); #1;
         vectors++;
         if (fdone !== (e == 30 || e == 60)) begin
            miscompares++;
            $display("FAIL frame_timing edge %0d got %b expected %b", e, fdone, (e == 30 || e == 60));
         end
      end
   endtask

   task automatic test_patterns;
      logic [5:0]  tf1 [5];
      logic [7:0]  tf2 [5];
      logic [8:0]  tpw [5];
      logic        tbl [5];
      logic [63:0] texp [5];
      logic [7:0]  s;
      bit          ok;
      tf1[0] = 6'd1;  tf2[0] = 8'd2;   tpw[0] = 9'd128; tbl[0] = 1'b1; texp[0] = 64'h00_06_00_00_5B_06_5B_7F;
      tf1[1] = 6'd1;  tf2[1] = 8'd2;   tpw[1] = 9'd128; tbl[1] = 1'b0; texp[1] = 64'h3F_06_3F_3F_5B_06_5B_7F;
      tf1[2] = 6'd0;  tf2[2] = 8'd0;   tpw[2] = 9'd0;   tbl[2] = 1'b1; texp[2] = 64'h00_3F_00_00_3F_00_00_3F;
      tf1[3] = 6'd63; tf2[3] = 8'd255; tpw[3] = 9'd511; tbl[3] = 1'b1; texp[3] = 64'h7D_4F_5B_6D_6D_6D_06_06;
      tf1[4] = 6'd10; tf2[4] = 8'd7;   tpw[4] = 9'd105; tbl[4] = 1'b1; texp[4] = 64'h06_3F_00_00_07_06_3F_6D;
      for (int v = 0; v < 5; v++) begin
         f1 = tf1[v]; f2 = tf2[v]; pw = tpw[v]; blank = tbl[v];
         wait_cycles(70);
         for (int i = 0; i < 8; i++) begin
            get_digit(i, s, ok);
            vectors++;
            if (!ok || s !== texp[v][8*i +: 8]) begin
               miscompares++;
               $display("FAIL pattern%0d digit %0d got %h expected %h (seen=%0d)", v, i, s, texp[v][8*i +: 8], ok);
            end
         end
      end
   endtask

   task automatic test_overflow;
      logic [55:0] exp_ov;
      logic [23:0] exp_b;
      logic [7:0]  s;
      bit          ok;
      f1 = 6'd1; f2 = 8'd255; pw = 9'd128; blank = 1'b1;
      exp_ov = 56'h00_06_40_40_06_5B_7F;
      exp_b  = 24'h5B_6D_6D;
      wait_cycles(70);
      for (int i = 0; i < 7; i++) begin
         get_digit_ov(i, s, ok);
         vectors++;
         if (!ok || s !== exp_ov[8*i +: 8]) begin
            miscompares++;
            $display("FAIL overflow digit %0d got %h expected %h (seen=%0d)", i, s, exp_ov[8*i +: 8], ok);
         end
      end
      for (int i = 3; i < 6; i++) begin
         get_digit(i, s, ok);
         vectors++;
         if (!ok || s !== exp_b[8*(i-3) +: 8]) begin
            miscompares++;
            $display("FAIL no_overflow digit %0d got %h expected %h (seen=%0d)", i, s, exp_b[8*(i-3) +: 8], ok);
         end
      end
   endtask

   task automatic test_scan;
      bit          ok;
      logic [7:0]  ecat;
      dp = 8'h01;
      wait_cycles(4);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (cat === 8'h7F) ok = 1'b1;
      end
      if (ok) begin
         ok = 1'b0;
         for (int c = 0; c < 5 && !ok; c++) begin
            @(negedge clk);
            if (cat === 8'hFF) ok = 1'b1;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL scan_sync got %h expected slot boundary after digit 7", cat);
      end else begin
         for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < 4; c++) begin
               if (s != 0 || c != 0) @(negedge clk);
               ecat = (c == 0) ? 8'hFF : ~(8'd1 << (s % 8));
               vectors++;
               if (cat !== ecat) begin
                  miscompares++;
                  $display("FAIL scan_cat slot %0d cyc %0d got %h expected %h", s, c, cat, ecat);
               end
               if (c == 0) begin
                  vectors++;
                  if (seg !== 8'h00) begin
                     miscompares++;
                     $display("FAIL scan_dark slot %0d got %h expected 00", s, seg);
                  end
               end
               if (c == 2 && (s == 0 || s == 8)) begin
                  vectors++;
                  if (seg !== 8'hFF) begin
                     miscompares++;
                     $display("FAIL scan_dp0 slot %0d got %h expected ff", s, seg);
                  end
               end
               if (c == 2 && s == 1) begin
                  vectors++;
                  if (seg !== 8'h5B) begin
                     miscompares++;
                     $display("FAIL scan_dp1 got %h expected 5b", seg);
                  end
               end
            end
         end
      end
      dp = 8'h00;
   endtask

   task automatic test_reset_mid_frame;
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      // twelve edges in: field B is being shifted
      for (int e = 1; e <= 12; e++) begin @(posedge clk); #1; end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (seg !== 8'h00) begin miscompares++; $display("FAIL midrst_seg got %h expected 00", seg); end
      vectors++;
      if (cat !== 8'hFF) begin miscompares++; $display("FAIL midrst_cat got %h expected ff", cat); end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (fdone !== 1'b0) begin miscompares++; $display("FAIL midrst_hold_fdone got %b expected 0", fdone); end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 31; e++) begin
         @(posedge clk); #1;
         vectors++;
         if (fdone !== (e == 30)) begin
            miscompares++;
            $display("FAIL midrst_restart edge %0d got %b expected %b", e, fdone, (e == 30));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_patterns;
      test_overflow;
      test_scan;
      test_reset_mid_frame;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
